regfile_write_arbiter: RTL and testbench

- Shares the single write port of the 8x8 register file between NUM_REQ requesters (ALU writeback, load unit, and so on) using round-robin arbitration and a valid/ready handshake.
- Registers the winning request into a one-entry output stage that drives the register file wr_en/wr_addr/wr_data pins.
- Provides combinational forwarding for the two read ports. While a write sits in the output stage, the register file array still holds the old value, so the forward path covers that cycle.

---
 rtl/regfile_write_arbiter_if.sv | 39 +++
 rtl/regfile_write_arbiter.sv | 116 +++++++++++
 tb/tb_regfile_write_arbiter.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/regfile_write_arbiter_if.sv
// Bundle of the requester handshake, register-file write pins and the
// read-port forwarding signals shared between the arbiter and its environment.
interface regfile_write_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 3
);
    logic                        hold;
    logic [NUM_REQ-1:0]          req_valid;
    logic [NUM_REQ*ADDR_W-1:0]   req_addr;
    logic [NUM_REQ*DATA_W-1:0]   req_data;
    logic [NUM_REQ-1:0]          req_ready;

    logic                        wr_en;
    logic [ADDR_W-1:0]           wr_addr;
    logic [DATA_W-1:0]           wr_data;

    logic [ADDR_W-1:0]           rd_addr1;
    logic [ADDR_W-1:0]           rd_addr2;
    logic                        fwd_hit1;
    logic                        fwd_hit2;
    logic [DATA_W-1:0]           fwd_data;

    logic [15:0]                 wr_count;

    // Environment side: requesters and read-port mirrors drive, results return.
    modport master (
        output hold, req_valid, req_addr, req_data, rd_addr1, rd_addr2,
        input  req_ready, wr_en, wr_addr, wr_data,
        input  fwd_hit1, fwd_hit2, fwd_data, wr_count
    );

    // Arbiter side.
    modport slave (
        input  hold, req_valid, req_addr, req_data, rd_addr1, rd_addr2,
        output req_ready, wr_en, wr_addr, wr_data,
        output fwd_hit1, fwd_hit2, fwd_data, wr_count
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register file write port between NUM_REQ
// requesters. The winner is captured into a one-entry output stage that drives
// the register file; forwarding flags cover the cycle where the array still
// holds the old value.
module regfile_write_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    regfile_write_arbiter_if.slave bus
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int SUM_W = PTR_W + 1;
    localparam logic [SUM_W-1:0] NUM_REQ_S = SUM_W'(NUM_REQ);

    logic [PTR_W-1:0]     ptr;
    logic [PTR_W-1:0]     ptr_next;
    logic [SUM_W-1:0]     ptr_sum;

    logic [2*NUM_REQ-1:0] valid_dbl;
    logic [NUM_REQ-1:0]   valid_rot;
    logic                 found;
    logic [SUM_W-1:0]     win_sum;
    logic [PTR_W-1:0]     win_idx;

    logic [NUM_REQ-1:0]   grant;
    logic [ADDR_W-1:0]    win_addr;
    logic [DATA_W-1:0]    win_data;
    logic                 transfer;

    logic                 wr_en_q;
    logic [ADDR_W-1:0]    wr_addr_q;
    logic [DATA_W-1:0]    wr_data_q;
    logic [15:0]          wr_count_q;

    // Rotate the request vector so the current priority holder sits at bit 0,
    // pick the lowest set bit, then map the offset back to a requester index.
    always_comb begin
        valid_dbl = {bus.req_valid, bus.req_valid};
        valid_rot = NUM_REQ'(valid_dbl >> ptr);
        found     = 1'b0;
        win_sum   = '0;
        if (reset && !bus.hold) begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                if (!found && valid_rot[k]) begin
                    found   = 1'b1;
                    win_sum = {1'b0, ptr} + SUM_W'(k);
                end
            end
        end
        if (win_sum >= NUM_REQ_S) begin
            win_sum = win_sum - NUM_REQ_S;
        end
        win_idx = win_sum[PTR_W-1:0];
    end

    // Decode the winner into a one-hot grant and select its address/data.
    always_comb begin
        grant    = '0;
        win_addr = '0;
        win_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (found && (win_idx == PTR_W'(i))) begin
                grant[i] = 1'b1;
                win_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
                win_data = bus.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Priority moves to the requester just after the winner, wrapping at NUM_REQ.
    always_comb begin
        ptr_sum = {1'b0, win_idx} + SUM_W'(1);
        if (ptr_sum >= NUM_REQ_S) begin
            ptr_sum = '0;
        end
        ptr_next = ptr_sum[PTR_W-1:0];
    end

    // A grant is only issued against a valid request, so grant implies transfer.
    assign transfer = found;

    // Output stage, round-robin pointer and saturating grant counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_count_q <= '0;
            ptr        <= '0;
        end else if (transfer) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= win_addr;
            wr_data_q <= win_data;
            ptr       <= ptr_next;
            if (wr_count_q != '1) begin
                wr_count_q <= wr_count_q + 16'd1;
            end
        end else begin
            wr_en_q <= 1'b0;
        end
    end

    assign bus.req_ready = grant;
    assign bus.wr_en     = wr_en_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.wr_count  = wr_count_q;

    // Forwarding only reflects the write currently sitting in the output stage.
    assign bus.fwd_hit1  = wr_en_q && (wr_addr_q == bus.rd_addr1);
    assign bus.fwd_hit2  = wr_en_q && (wr_addr_q == bus.rd_addr2);
    assign bus.fwd_data  = wr_data_q;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: reset, single grant, round-robin,
// same-address collision, forwarding, hold and reset in the middle of a burst.
module tb_regfile_write_arbiter;
    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 8;
    localparam int ADDR_W  = 3;

    logic clk = 1'b0;
    logic reset;
    int unsigned tests_run    = 0;
    int unsigned tests_failed = 0;
    logic [DATA_W-1:0] rf [8];

    regfile_write_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    regfile_write_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Register file array the arbiter writes into.
    always @(posedge clk) begin
        if (bus.wr_en) rf[bus.wr_addr] <= bus.wr_data;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_req(input int i, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bus.req_addr[i*ADDR_W +: ADDR_W] = a;
        bus.req_data[i*DATA_W +: DATA_W] = d;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    initial begin
        reset        = 1'b0;
        bus.hold     = 1'b0;
        bus.req_valid = '0;
        bus.req_addr = '0;
        bus.req_data = '0;
        bus.rd_addr1 = '0;
        bus.rd_addr2 = '0;

        // Requests raised while in reset must not be granted.
        bus.req_valid = 4'b1111;
        settle();
        check_eq("rst_ready_held", 32'(bus.req_ready), 32'h0);
        tick();
        tick();
        check_eq("rst_wr_en",    32'(bus.wr_en),    32'h0);
        check_eq("rst_wr_addr",  32'(bus.wr_addr),  32'h0);
        check_eq("rst_wr_data",  32'(bus.wr_data),  32'h0);
        check_eq("rst_wr_count", 32'(bus.wr_count), 32'h0);

        // 1. single request from requester 0
        bus.req_valid = 4'b0001;
        set_req(0, 3'd5, 8'hA5);
        reset = 1'b1;
        settle();
        check_eq("t1_ready", 32'(bus.req_ready), 32'b0001);
        tick();
        bus.req_valid = '0;
        check_eq("t1_wr_en",    32'(bus.wr_en),    32'h1);
        check_eq("t1_wr_addr",  32'(bus.wr_addr),  32'h5);
        check_eq("t1_wr_data",  32'(bus.wr_data),  32'hA5);
        check_eq("t1_wr_count", 32'(bus.wr_count), 32'h1);
        settle();
        check_eq("t1_idle_ready", 32'(bus.req_ready), 32'h0);
        tick();
        check_eq("t1_wr_en_drop",  32'(bus.wr_en),   32'h0);
        check_eq("t1_wr_addr_hold", 32'(bus.wr_addr), 32'h5);

        // 2. round-robin with everyone valid
        for (int i = 0; i < NUM_REQ; i++) set_req(i, ADDR_W'(i), DATA_W'(8'h10 + i));
        do_reset();
        bus.req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            settle();
            check_eq($sformatf("t2_ready_%0d", k), 32'(bus.req_ready), 32'(1 << (k % 4)));
            tick();
            check_eq($sformatf("t2_wr_en_%0d", k),   32'(bus.wr_en),   32'h1);
            check_eq($sformatf("t2_wr_data_%0d", k), 32'(bus.wr_data), 32'(8'h10 + (k % 4)));
        end
        check_eq("t2_wr_count", 32'(bus.wr_count), 32'd5);
        bus.req_valid = '0;

        // 3. same address from requesters 1 and 2
        set_req(1, 3'd2, 8'h11);
        set_req(2, 3'd2, 8'h22);
        do_reset();
        bus.req_valid = 4'b0110;
        settle();
        check_eq("t3_ready_first", 32'(bus.req_ready), 32'b0010);
        tick();
        check_eq("t3_wr_data_first", 32'(bus.wr_data), 32'h11);
        check_eq("t3_wr_addr_first", 32'(bus.wr_addr), 32'h2);
        bus.req_valid = 4'b0100;
        settle();
        check_eq("t3_ready_second", 32'(bus.req_ready), 32'b0100);
        tick();
        check_eq("t3_wr_data_second", 32'(bus.wr_data), 32'h22);
        bus.req_valid = '0;
        tick();
        check_eq("t3_wr_en_idle", 32'(bus.wr_en), 32'h0);
        check_eq("t3_rf2_final",  32'(rf[2]),     32'h22);

        // 4. forwarding (pointer now at 3, so requester 0 wins after the wrap)
        set_req(0, 3'd3, 8'h7E);
        bus.rd_addr1 = 3'd3;
        bus.rd_addr2 = 3'd4;
        bus.req_valid = 4'b0001;
        settle();
        check_eq("t4_ready",       32'(bus.req_ready), 32'b0001);
        check_eq("t4_no_fwd_pre",  32'(bus.fwd_hit1),  32'h0);
        tick();
        bus.req_valid = '0;
        check_eq("t4_fwd_hit1", 32'(bus.fwd_hit1), 32'h1);
        check_eq("t4_fwd_hit2", 32'(bus.fwd_hit2), 32'h0);
        check_eq("t4_fwd_data", 32'(bus.fwd_data), 32'h7E);
        tick();
        check_eq("t4_fwd_hit1_after", 32'(bus.fwd_hit1), 32'h0);
        check_eq("t4_fwd_hit2_after", 32'(bus.fwd_hit2), 32'h0);

        // 5. hold (pointer now at 1)
        for (int i = 0; i < NUM_REQ; i++) set_req(i, ADDR_W'(i), DATA_W'(8'h10 + i));
        bus.req_valid = 4'b1111;
        settle();
        check_eq("t5_ready_pre", 32'(bus.req_ready), 32'b0010);
        tick();
        check_eq("t5_wr_data_pre", 32'(bus.wr_data), 32'h11);
        bus.hold = 1'b1;
        check_eq("t5_inflight_wr_en", 32'(bus.wr_en), 32'h1);
        for (int c = 0; c < 3; c++) begin
            settle();
            check_eq($sformatf("t5_hold_ready_%0d", c), 32'(bus.req_ready), 32'h0);
            tick();
            check_eq($sformatf("t5_hold_wr_en_%0d", c), 32'(bus.wr_en), 32'h0);
        end
        bus.hold = 1'b0;
        settle();
        check_eq("t5_resume_ready", 32'(bus.req_ready), 32'b0100);
        tick();
        check_eq("t5_resume_wr_data", 32'(bus.wr_data),  32'h12);
        check_eq("t5_wr_count",       32'(bus.wr_count), 32'd5);

        // 6. reset in the middle of a burst
        settle();
        check_eq("t6_ready_pre", 32'(bus.req_ready), 32'b1000);
        tick();
        check_eq("t6_wr_data_pre", 32'(bus.wr_data),  32'h13);
        check_eq("t6_wr_count_pre", 32'(bus.wr_count), 32'd6);
        reset = 1'b0;
        settle();
        check_eq("t6_rst_ready",    32'(bus.req_ready), 32'h0);
        check_eq("t6_inflight_wr_en", 32'(bus.wr_en),   32'h1);
        tick();
        check_eq("t6_rst_wr_en",    32'(bus.wr_en),    32'h0);
        check_eq("t6_rst_wr_count", 32'(bus.wr_count), 32'h0);
        reset = 1'b1;
        settle();
        check_eq("t6_post_ready", 32'(bus.req_ready), 32'b0001);
        tick();
        check_eq("t6_post_wr_data",  32'(bus.wr_data),  32'h10);
        check_eq("t6_post_wr_count", 32'(bus.wr_count), 32'h1);
        bus.req_valid = '0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
